// File: rtl/debounce_scan_ctrl.sv
// Time-multiplexed debouncer: N synchronized inputs share one integrate-and-compare
// step on a round-robin slot schedule; level changes are reported on a one-entry event port.
module debounce_scan_ctrl #(
  parameter int N        = 4,
  parameter int CNT_W    = 3,
  parameter int PRESCALE = 4,
  localparam int CHAN_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      in,
  output logic [N-1:0]      out,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CHAN_W-1:0] evt_chan,
  output logic              evt_level,
  output logic              evt_ovf,
  input  logic              ovf_clr
);

  localparam int PC_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int THRESH = (1 << CNT_W) - 1;

  logic [N-1:0]      sync_p0;
  logic [N-1:0]      sync_p1;
  logic [PC_W-1:0]   pc;
  logic [CHAN_W-1:0] idx;
  logic [CNT_W-1:0]  cnt [N];
  logic              slot;
  logic              cur_sync;
  logic              cur_out;
  logic [CNT_W-1:0]  cur_cnt;
  logic              gen_evt;

  // Stage p0 -> p1: two-flop synchronizer on every raw input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= in;
      sync_p1 <= sync_p0;
    end
  end

  // Slot timing and round-robin scan index
  assign slot = (pc == PC_W'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= '0;
      idx <= '0;
    end else if (slot) begin
      pc  <= '0;
      idx <= (idx == CHAN_W'(N - 1)) ? '0 : idx + CHAN_W'(1);
    end else begin
      pc  <= pc + PC_W'(1);
    end
  end

  // Shared compare step: select the channel being served this slot
  always_comb begin
    cur_sync = 1'b0;
    cur_out  = 1'b0;
    cur_cnt  = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == CHAN_W'(k)) begin
        cur_sync = sync_p1[k];
        cur_out  = out[k];
        cur_cnt  = cnt[k];
      end
    end
  end

  assign gen_evt = slot && (cur_sync != cur_out) && (cur_cnt == CNT_W'(THRESH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
      for (int k = 0; k < N; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (slot && (idx == CHAN_W'(k))) begin
          if (sync_p1[k] == out[k]) begin
            cnt[k] <= '0;
          end else if (cnt[k] == CNT_W'(THRESH - 1)) begin
            out[k] <= sync_p1[k];
            cnt[k] <= '0;
          end else begin
            cnt[k] <= cnt[k] + CNT_W'(1);
          end
        end
      end
    end
  end

  // One-entry event register; a new event may replace an entry popped the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_chan  <= '0;
      evt_level <= 1'b0;
      evt_ovf   <= 1'b0;
    end else begin
      if (gen_evt && (!evt_valid || evt_ready)) begin
        evt_valid <= 1'b1;
        evt_chan  <= idx;
        evt_level <= cur_sync;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end

      if (gen_evt && evt_valid && !evt_ready) begin
        evt_ovf <= 1'b1;
      end else if (ovf_clr) begin
        evt_ovf <= 1'b0;
      end
    end
  end

endmodule
